host_cmd_ctrl: RTL and testbench
================================

# host_cmd_ctrl

UART host command controller for the NES FPGA top level. It decodes the byte stream from `uart_rx` into host commands: write byte, read byte, hold CPU and release CPU. It sequences one CPU-bus transaction per command and returns read data through `UART_TX`. It owns the `cpu_halt` line, which gives the host exclusive access to the CPU memory bus, including PGROM, RAM and the PPU registers at $2006/$2007.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 250000: idle clocks allowed between bytes of one command before the partial command is dropped (10 ms at 25 MHz).
- `RD_ERR_BYTE`, default 8'hFF: byte returned for a read issued while the CPU is not halted.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: 25 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe, received byte valid.
- `rx_data` in 8: received byte.
- `tx_start` out 1: one-cycle strobe to `UART_TX`.
- `tx_data` out 8: byte to transmit; held stable while `tx_active`.
- `tx_active` in 1: transmitter busy.
- `bus_req` out 1: bus transaction request; level, held until ack.
- `bus_we` out 1: 1 = write, 0 = read; valid with `bus_req`.
- `bus_addr` out 16: CPU-space address.
- `bus_wdata` out 8: write data.
- `bus_ack` in 1: one-cycle completion strobe.
- `bus_rdata` in 8: read data, valid in the `bus_ack` cycle.
- `cpu_halt` out 1: 1 = CPU and PPU held, host owns the bus.
- `cmd_err` out 1: one-cycle pulse on an unknown opcode, a timeout, a dropped byte, or a read/write rejected because the CPU is running.

## Operation
Opcodes:
- 8'h02 WRITE: followed by addr_hi, addr_lo, data.
- 8'h03 READ: followed by addr_hi, addr_lo; one byte is returned.
- 8'h06 HALT: sets `cpu_halt`.
- 8'h07 RUN: clears `cpu_halt`.
- Any other opcode in IDLE: ignored, `cmd_err` pulses.

States: IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX_WAIT.
- IDLE: `rx_valid` with 02/03 → ADDR_HI; with 06/07 → update `cpu_halt`, stay in IDLE.
- ADDR_HI → ADDR_LO on `rx_valid`; ADDR_LO → DATA (WRITE) or BUS (READ); DATA → BUS.
- BUS with `cpu_halt`=1: assert `bus_req`; on `bus_ack`, WRITE → IDLE, READ → capture `bus_rdata` into `tx_data`, then → TX_WAIT.
- BUS with `cpu_halt`=0: no bus request; `cmd_err` pulses. WRITE → IDLE. READ loads `RD_ERR_BYTE` into `tx_data` → TX_WAIT, so the host never hangs.
- TX_WAIT: when `tx_active`=0, pulse `tx_start` for one cycle → IDLE.
- Timeout: in ADDR_HI/ADDR_LO/DATA a counter counts cycles without `rx_valid`; reaching `TIMEOUT_CYCLES` → IDLE, `cmd_err`. The counter clears on every accepted byte.
- `rx_valid` in BUS or TX_WAIT: byte dropped, `cmd_err`.
- HALT while already halted, or RUN while running: no change, no error.
- `cpu_halt` never changes during BUS or TX_WAIT, because opcodes are only decoded in IDLE.

## Timing
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `tx_start`=0, `tx_data`=0, `cpu_halt`=0, `cmd_err`=0, state IDLE, timeout counter 0.
- `rst` mid-transaction: every output returns to its reset value on the next edge. `bus_req` drops even without an ack; the bus slave must tolerate this.
- `bus_req` rises the cycle after the final payload byte's `rx_valid`. `bus_addr`/`bus_we`/`bus_wdata` are stable from that cycle until after `bus_ack`. `bus_req` falls the cycle after `bus_ack`.
- Zero-wait-state slave with ack in the first req cycle: command-end to IDLE is 2 cycles for WRITE.
- READ: `tx_start` pulses 1 cycle after entering TX_WAIT if `tx_active`=0, otherwise in the cycle after `tx_active` falls.
- HALT/RUN: `cpu_halt` changes on the edge after the opcode's `rx_valid`.
- `cmd_err` is registered and is never asserted for more than 1 cycle per event.

## Structure
- Add the opcode constants (CMD_WRITE=8'h02, CMD_READ=8'h03, CMD_HALT=8'h06, CMD_RUN=8'h07) and the `host_cmd_state_t` enum to `ie_defs`.
- One sub-module, `host_timeout_ctr`, handles the inter-byte timeout: inputs `clk`, `rst`, `clr`, `en`; output `expired`. The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates.
- Everything else is a single FSM plus registers in `host_cmd_ctrl`.

## Test plan
- Send 06, then 02 80 00 A9 → `cpu_halt`=1; one bus write: addr 16'h8000, data 8'hA9, `bus_we`=1; `bus_req` cleared the cycle after ack; no `cmd_err`.
- Send 06, then 03 20 07 with the slave acking 8'h3C after 4 wait cycles → exactly one `tx_start` with `tx_data`=8'h3C.
- Send 03 00 10 with `cpu_halt`=0 → no `bus_req`; `cmd_err` pulses; `tx_data`=8'hFF is transmitted.
- Send 02 12 followed by silence for `TIMEOUT_CYCLES` → `cmd_err`, return to IDLE. A following 07 is then accepted as an opcode.
- Hold `tx_active`=1 for 100 cycles during a READ, inject an `rx_valid` during that wait, and pulse `rst` during a subsequent write's BUS state:
  - `tx_start` is delayed until `tx_active` falls.
  - The injected byte causes a `cmd_err`.
  - After the reset edge, `bus_req`=0 and `cpu_halt`=0.
- Send 55, then 07 → `cmd_err` for the 55; `cpu_halt` stays 0.

Source files
------------

// File: rtl/host_cmd_ctrl_pkg.sv
// Shared definitions for the UART host command controller.
// Opcodes and FSM state encoding.
package ie_defs;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_HALT  = 8'h06;
    localparam logic [7:0] CMD_RUN   = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_BUS,
        ST_TX_WAIT
    } host_cmd_state_t;

    function automatic logic in_payload(host_cmd_state_t s);
        return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
               (s == ST_DATA);
    endfunction

endpackage

// File: rtl/host_cmd_ctrl_if.sv
// CPU memory bus port between the host controller and the bus slave.
// Level request, one-cycle ack, read data valid with ack.
interface host_cmd_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/host_cmd_ctrl_timeout.sv
// Saturating inter-byte idle counter for partially received commands.
// expired stays high until cleared.
module host_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != LIM)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LIM);
endmodule

// File: rtl/host_cmd_ctrl.sv
// UART host command decoder: write/read CPU bus bytes, halt/run CPU.
// One bus transaction per command; read data goes back via UART_TX.
module host_cmd_ctrl
    import ie_defs::*;
#(
    parameter int          TIMEOUT_CYCLES = 250000,
    parameter logic [7:0]  RD_ERR_BYTE    = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_active,
    host_cmd_ctrl_if.master bus,
    output logic       cpu_halt,
    output logic       cmd_err
);
    host_cmd_state_t state_q, state_d;

    logic        is_rd_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  tx_q;
    logic        halt_q, halt_d;
    logic        err_q, err_d;
    logic        txs_q, txs_d;
    logic        op_rw, ld_hi, ld_lo, ld_dat;
    logic        ld_rd, ld_fail;
    logic        expired;
    logic        payload;

    assign payload = in_payload(state_q);

    host_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_to (
        .clk    (clk),
        .rst    (rst),
        .clr    (!payload || rx_valid),
        .en     (payload && !rx_valid),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        halt_d  = halt_q;
        err_d   = 1'b0;
        txs_d   = 1'b0;
        op_rw   = 1'b0;
        ld_hi   = 1'b0;
        ld_lo   = 1'b0;
        ld_dat  = 1'b0;
        ld_rd   = 1'b0;
        ld_fail = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    unique case (rx_data)
                        CMD_WRITE,
                        CMD_READ: begin
                            op_rw   = 1'b1;
                            state_d = ST_ADDR_HI;
                        end
                        CMD_HALT: halt_d = 1'b1;
                        CMD_RUN:  halt_d = 1'b0;
                        default:  err_d  = 1'b1;
                    endcase
                end
            end
            ST_ADDR_HI: begin
                if (rx_valid) begin
                    ld_hi   = 1'b1;
                    state_d = ST_ADDR_LO;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR_LO: begin
                if (rx_valid) begin
                    ld_lo   = 1'b1;
                    state_d = is_rd_q ? ST_BUS : ST_DATA;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    ld_dat  = 1'b1;
                    state_d = ST_BUS;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                err_d = rx_valid;
                // Running CPU owns the bus: reject, but still answer reads.
                if (!halt_q) begin
                    err_d   = 1'b1;
                    ld_fail = is_rd_q;
                    state_d = is_rd_q ? ST_TX_WAIT : ST_IDLE;
                end else if (bus.bus_ack) begin
                    ld_rd   = is_rd_q;
                    state_d = is_rd_q ? ST_TX_WAIT : ST_IDLE;
                end
            end
            ST_TX_WAIT: begin
                err_d = rx_valid;
                if (!tx_active) begin
                    txs_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_rd_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tx_q    <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            txs_q   <= 1'b0;
        end else begin
            halt_q <= halt_d;
            err_q  <= err_d;
            txs_q  <= txs_d;
            if (op_rw)
                is_rd_q <= (rx_data == CMD_READ);
            if (ld_hi)
                addr_q[15:8] <= rx_data;
            if (ld_lo)
                addr_q[7:0] <= rx_data;
            if (ld_dat)
                wdata_q <= rx_data;
            if (ld_rd)
                tx_q <= bus.bus_rdata;
            else if (ld_fail)
                tx_q <= RD_ERR_BYTE;
        end
    end

    assign bus.bus_req   = (state_q == ST_BUS) && halt_q;
    assign bus.bus_we    = (state_q == ST_BUS) && !is_rd_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

    assign tx_start = txs_q;
    assign tx_data  = tx_q;
    assign cpu_halt = halt_q;
    assign cmd_err  = err_q;
endmodule

// File: tb/tb_host_cmd_ctrl.sv
// Scoreboard bench for host_cmd_ctrl: directed command streams,
// expected bus/tx/err events queued and matched by a monitor.
module tb_host_cmd_ctrl;
    localparam int TO = 40;
    localparam int EV_BUS = 0;
    localparam int EV_TX  = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_active = 1'b0;
    logic       cpu_halt;
    logic       cmd_err;

    host_cmd_ctrl_if bif ();

    host_cmd_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .RD_ERR_BYTE   (8'hFF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_active(tx_active),
        .bus      (bif),
        .cpu_halt (cpu_halt),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    int       wait_n = 0;
    logic [7:0] slave_data = 8'h00;
    int       wcnt = 0;

    initial begin
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bif.bus_ack = 1'b0;
            if (bif.bus_req) begin
                if (wcnt == wait_n) begin
                    bif.bus_ack   = 1'b1;
                    bif.bus_rdata = slave_data;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [15:0] a,
                        input logic w, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.we   = w;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [15:0] a,
                           input logic w, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d expected none",
                     k);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k) begin
            failures++;
            $display("FAIL event_kind: got %0d expected %0d", k, e.kind);
        end else if (k == EV_BUS &&
                     (a !== e.addr || w !== e.we ||
                      (w && d !== e.data))) begin
            failures++;
            $display("FAIL bus_event: got a=%h we=%b d=%h expected a=%h we=%b d=%h",
                     a, w, d, e.addr, e.we, e.data);
        end else if (k == EV_TX && d !== e.data) begin
            failures++;
            $display("FAIL tx_data: got %h expected %h", d, e.data);
        end
    endtask

    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bif.bus_ack)
                chk("req_fall_after_ack", 32'(bif.bus_req), 0);
            if (bif.bus_req && !prev_req)
                observe(EV_BUS, bif.bus_addr, bif.bus_we,
                        bif.bus_wdata);
            if (tx_start) begin
                chk("tx_start_while_active", 32'(tx_active), 0);
                observe(EV_TX, 16'h0, 1'b0, tx_data);
            end
            if (cmd_err)
                observe(EV_ERR, 16'h0, 1'b0, 8'h00);
            prev_req = bif.bus_req;
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d events outstanding expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bus_req",   32'(bif.bus_req), 0);
        chk("rst_bus_we",    32'(bif.bus_we), 0);
        chk("rst_bus_addr",  32'(bif.bus_addr), 0);
        chk("rst_bus_wdata", 32'(bif.bus_wdata), 0);
        chk("rst_tx_start",  32'(tx_start), 0);
        chk("rst_tx_data",   32'(tx_data), 0);
        chk("rst_cpu_halt",  32'(cpu_halt), 0);
        chk("rst_cmd_err",   32'(cmd_err), 0);

        // halted zero-wait write
        send(8'h06);
        chk("halt_set", 32'(cpu_halt), 1);
        wait_n = 0;
        push(EV_BUS, 16'h8000, 1'b1, 8'hA9);
        send(8'h02); send(8'h80); send(8'h00); send(8'hA9);
        drain("write_8000", 50);

        // halted read, 4 wait states
        wait_n = 4;
        slave_data = 8'h3C;
        push(EV_BUS, 16'h2007, 1'b0, 8'h00);
        push(EV_TX, 16'h0, 1'b0, 8'h3C);
        send(8'h03); send(8'h20); send(8'h07);
        drain("read_2007", 50);

        // transmitter busy for 100 cycles plus a stray byte
        tx_active = 1'b1;
        wait_n = 2;
        slave_data = 8'h5A;
        push(EV_BUS, 16'h1234, 1'b0, 8'h00);
        push(EV_ERR, 16'h0, 1'b0, 8'h00);
        push(EV_TX, 16'h0, 1'b0, 8'h5A);
        send(8'h03); send(8'h12); send(8'h34);
        repeat (10) @(negedge clk);
        send(8'h99);
        repeat (88) @(negedge clk);
        chk("tx_held_pending", 32'(exp_q.size()), 1);
        tx_active = 1'b0;
        drain("read_tx_busy", 50);

        // reset while a write waits in BUS
        wait_n = 20;
        push(EV_BUS, 16'h0300, 1'b1, 8'h11);
        send(8'h02); send(8'h03); send(8'h00); send(8'h11);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_bus_req",  32'(bif.bus_req), 0);
        chk("rst_mid_cpu_halt", 32'(cpu_halt), 0);
        drain("write_reset", 10);
        wait_n = 0;

        // inter-byte timeout, then RUN accepted as opcode
        send(8'h06);
        chk("halt_again", 32'(cpu_halt), 1);
        push(EV_ERR, 16'h0, 1'b0, 8'h00);
        send(8'h02); send(8'h12);
        repeat (TO - 5) @(negedge clk);
        chk("timeout_early", 32'(exp_q.size()), 1);
        drain("timeout", 30);
        send(8'h07);
        chk("run_after_timeout", 32'(cpu_halt), 0);

        // read while CPU running
        push(EV_ERR, 16'h0, 1'b0, 8'h00);
        push(EV_TX, 16'h0, 1'b0, 8'hFF);
        send(8'h03); send(8'h00); send(8'h10);
        drain("read_running", 50);

        // unknown opcode, then RUN while running
        push(EV_ERR, 16'h0, 1'b0, 8'h00);
        send(8'h55);
        send(8'h07);
        chk("halt_stays_low", 32'(cpu_halt), 0);
        drain("bad_opcode", 20);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time limit reached");
        $fatal(1);
    end
endmodule
